psan_sigmoid_sched: RTL

- Shares one psan_sigmoid core between N_REQ requesters using round-robin arbitration.
- Uses sigmoid symmetry: the core only ever sees |x|, and the block returns 1 - f for negative inputs.
- Retags each result with the requester ID and buffers it in a small output FIFO with valid/ready backpressure.
- Sits between the neuron datapath lanes and the single sigmoid core instance.

---
 rtl/psan_sigmoid_sched_pkg.sv | 38 +++
 rtl/psan_sigmoid_sched_rr_arbiter.sv | 54 +++++
 rtl/psan_sigmoid_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/psan_sigmoid_sched_pkg.sv
// rtl/psan_sigmoid_sched_pkg.sv - shared types and sigmoid symmetry helpers
package psan_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;
  // Wide enough for up to 8 requesters
  localparam int ID_W   = 3;
  localparam logic [DATA_W-1:0] ONE_Q = DATA_W'(1 << FRAC_W);

  typedef logic signed [DATA_W-1:0] q_t;
  typedef logic        [DATA_W-1:0] uq_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    uq_t             fx;
  } rsp_t;

  // Magnitude of a signed operand; the most negative code has no positive twin
  function automatic uq_t abs_sat(input q_t x);
    uq_t r;
    if (!x[DATA_W-1]) begin
      r = uq_t'(x);
    end else if (x == {1'b1, {(DATA_W-1){1'b0}}}) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = uq_t'(-x);
    end
    return r;
  endfunction

  // Clamp the core result to one, then mirror it for negative operands
  function automatic uq_t sym_fix(input logic neg, input uq_t fx);
    uq_t sat;
    sat = (fx > ONE_Q) ? ONE_Q : fx;
    return neg ? (ONE_Q - sat) : sat;
  endfunction

endpackage

// File: rtl/psan_sigmoid_sched_rr_arbiter.sv
// rtl/psan_sigmoid_sched_rr_arbiter.sv - round-robin one-hot arbiter with rotating priority
module psan_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     enable_i,
  input  logic                     upd_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;
  int            j;

  // First requester at or above the pointer wins, wrapping past the top
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = PW'(j);
      if (enable_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
        found        = 1'b1;
      end
    end
  end

  // Priority moves just past the winner only when a transfer happened
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (grant_idx_o == PW'(N_REQ - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/psan_sigmoid_sched.sv
// rtl/psan_sigmoid_sched.sv - shares one sigmoid core between requesters with retagged FIFO output
module psan_sigmoid_sched
  import psan_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int CORE_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_x_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         core_x_o,
  input  logic [DATA_W-1:0]         core_fx_i,
  output logic                      rsp_valid_o,
  output logic [$clog2(N_REQ)-1:0]  rsp_id_o,
  output logic [DATA_W-1:0]         rsp_fx_o,
  input  logic                      rsp_ready_i,
  output logic                      busy_o
);

  localparam int PW    = $clog2(N_REQ);
  localparam int FPW   = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + CORE_LAT + 2);

  logic [N_REQ-1:0]  grant;
  logic [PW-1:0]     gidx;
  logic              can_issue, xfer;
  q_t                x_sel;

  uq_t               core_x_q;
  logic              iss_vld_q, iss_neg_q;
  logic [ID_W-1:0]   iss_id_q;
  logic [CORE_LAT-1:0] pipe_vld_q, pipe_neg_q;
  logic [ID_W-1:0]   pipe_id_q [CORE_LAT];

  rsp_t              mem_q [FIFO_DEPTH];
  logic [FPW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d, inflight;
  logic              push, pop;
  rsp_t              push_data, head;

  function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
    return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Entries issued to the core but not yet captured into the FIFO
  always_comb begin
    inflight = CNT_W'(iss_vld_q);
    for (int k = 0; k < CORE_LAT; k++) inflight = inflight + CNT_W'(pipe_vld_q[k]);
  end

  // Credit counts every slot a result could eventually need; pops free it a cycle later
  assign can_issue = (inflight + fifo_cnt_q) < CNT_W'(FIFO_DEPTH);

  psan_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_valid_i),
    .enable_i    (can_issue & ~reset_i),
    .upd_i       (xfer),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign req_ready_o = grant;
  assign xfer        = |(req_valid_i & grant);

  // Operand of the granted requester
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx == PW'(i)) x_sel = req_x_i[i*DATA_W +: DATA_W];
    end
  end

  // Issue stage: core operand plus the tag that travels alongside it
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_x_q  <= '0;
      iss_vld_q <= 1'b0;
      iss_id_q  <= '0;
      iss_neg_q <= 1'b0;
    end else begin
      iss_vld_q <= xfer;
      if (xfer) begin
        core_x_q  <= abs_sat(x_sel);
        iss_id_q  <= ID_W'(gidx);
        iss_neg_q <= x_sel[DATA_W-1];
      end
    end
  end

  assign core_x_o = core_x_q;

  // Tag pipeline matching the core latency so the tail lines up with core_fx
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_vld_q <= '0;
      pipe_neg_q <= '0;
      for (int k = 0; k < CORE_LAT; k++) pipe_id_q[k] <= '0;
    end else begin
      pipe_vld_q[0] <= iss_vld_q;
      pipe_neg_q[0] <= iss_neg_q;
      pipe_id_q[0]  <= iss_id_q;
      for (int k = 1; k < CORE_LAT; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_neg_q[k] <= pipe_neg_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
    end
  end

  assign push         = pipe_vld_q[CORE_LAT-1];
  assign push_data.id = pipe_id_q[CORE_LAT-1];
  assign push_data.fx = sym_fix(pipe_neg_q[CORE_LAT-1], core_fx_i);
  assign pop          = rsp_valid_o & rsp_ready_i;

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  // FIFO control registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until the count covers them
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head        = mem_q[rd_ptr_q];
  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_fx_o    = rsp_valid_o ? head.fx : '0;

  // Narrow the stored tag back to the port width
  always_comb begin
    rsp_id_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rsp_valid_o && head.id == ID_W'(i)) rsp_id_o = PW'(i);
    end
  end

  assign busy_o = (inflight != '0) || rsp_valid_o;

  // The credit rule must make a push into a full FIFO impossible
  assert property (@(posedge clk_i) disable iff (reset_i)
                   (push && !pop) |-> (fifo_cnt_q < CNT_W'(FIFO_DEPTH)));

endmodule
